shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
Sequential unsigned WIDTH x WIDTH multiplier built on the team's ripple-carry adder. Each step is one WIDTH-bit add plus one right shift, one step per clock. It sits directly upstream of the Ripple_Adder instance. It drives A/B/CIN from its internal partial-product registers and consumes SUM/COUT on the same cycle. A START/BUSY/DONE handshake connects it to the surrounding datapath.

Parameters:
WIDTH, 4, operand width in bits; the internal adder instance is WIDTH bits wide; the product is 2*WIDTH bits wide.

Ports:
CLK  input  1  rising-edge clock; the only clock
RST  input  1  asynchronous, active-high reset
START  input  1  request to multiply; sampled on the rising CLK edge
A  input  WIDTH  multiplicand; captured only when START is accepted
B  input  WIDTH  multiplier; captured only when START is accepted
BUSY  output  1  high while a multiplication is in progress
DONE  output  1  single-cycle pulse; PRODUCT is valid
PRODUCT  output  2*WIDTH  unsigned A*B; held stable from DONE until the next START is accepted

Behaviour:
- Interface: one clock (CLK). Reset RST is asynchronous and active-high.
- Reset values (RST high, immediate and independent of CLK):
  - state = IDLE; BUSY = 0; DONE = 0; PRODUCT = 0.
  - Internal registers are cleared: multiplicand M = 0, accumulator P (2*WIDTH+1 bits including carry) = 0, step counter = 0.
- States: IDLE, RUN, FIN. All outputs are registered. There are no combinational paths from inputs to outputs.
- Transition IDLE or FIN -> RUN, when START = 1 at an edge:
  - Load M <= A.
  - Load P <= {0 (carry), WIDTH zeros, B}.
  - Load counter <= WIDTH.
  - BUSY <= 1; DONE <= 0.
- RUN, each edge:
  - Adder inputs: A = P[2W-1:W], B = (P[0] ? M : 0), CIN = 0.
  - Update P <= {COUT, SUM, P[W-1:0]} >> 1. This is a logical right shift of the (2W+1)-bit value, so COUT lands in bit 2W-1.
  - Decrement the counter.
  - When the counter reaches 1 (last step):
    - Next state is FIN.
    - PRODUCT <= the shifted P[2W-1:0].
    - DONE <= 1; BUSY <= 0.
- FIN, exactly one cycle:
  - DONE <= 0 at the next edge.
  - Go to RUN if START = 1 (back-to-back accept), otherwise to IDLE.
- Latency: START accepted at edge t0. Steps occur at edges t1..tW. DONE is high for the cycle following edge tW. For WIDTH = 4, DONE is seen after the 5th edge counted from the accept edge.
- Throughput: one result every WIDTH+1 cycles with back-to-back START.
- START while in RUN: ignored. A and B are not recaptured and the operation in flight is unaffected. No queueing.
- A and B may change freely after the accept edge.
- PRODUCT changes only at the last RUN step. It is not cleared on accept, so the previous result remains readable while BUSY.
- Width rule:
  - The carry out of every step is kept, so there is no overflow.
  - (2^W-1)^2 fits in 2W bits.
- RST during RUN or FIN:
  - Immediate return to IDLE; BUSY = 0; DONE = 0; PRODUCT = 0.
  - The operation in flight is discarded.
  - No DONE pulse is produced after reset is released.
- START high while RST is high: ignored. The first accept is possible at the first edge after RST deasserts.

Test Plan:
- Reset, then A = 3, B = 5, START pulsed for one cycle -> BUSY = 1 for 4 cycles, DONE pulses once after the 5th edge, PRODUCT = 0x0F and holds.
- A = 15, B = 15 (exercises COUT on every add) -> PRODUCT = 0xE1.
- Zero operands: A = 0, B = 9 -> PRODUCT = 0x00. A = 9, B = 0 -> PRODUCT = 0x00. Both take full latency with one DONE pulse each.
- A = 6, B = 7 accepted, then START with A = 2, B = 2 asserted during RUN -> second request ignored, PRODUCT = 0x2A, exactly one DONE.
- START held high continuously with A = 12, B = 10 -> DONE every 5 cycles, PRODUCT = 0x78 each time, no idle gap.
- A = 13, B = 11 accepted, RST pulsed asynchronously mid-cycle two edges later -> BUSY, DONE and PRODUCT go to 0 immediately, with no later DONE. A new A = 2, B = 3 afterwards -> PRODUCT = 0x06.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one ripple-carry add
// and one right shift of the partial product per clock.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    logic [WIDTH:0] c;

    assign c[0] = CIN;
    assign COUT = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (SUM[i]),
            .co (c[i+1])
        );
    end
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PRODUCT
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH-1:0] p;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH:0]   pre;
    logic [2*WIDTH-1:0] p_next;

    assign add_a = p[2*WIDTH-1:WIDTH];
    assign add_b = p[0] ? m : '0;

    ripple_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .A    (add_a),
        .B    (add_b),
        .CIN  (1'b0),
        .SUM  (sum),
        .COUT (cout)
    );

    // Carry is kept above the sum, so the shift lands it in bit 2W-1.
    assign pre    = {cout, sum, p[WIDTH-1:0]};
    assign p_next = pre[2*WIDTH:1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            m       <= '0;
            p       <= '0;
            cnt     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            PRODUCT <= '0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        m     <= A;
                        p     <= {{WIDTH{1'b0}}, B};
                        cnt   <= CW'(WIDTH);
                        BUSY  <= 1'b1;
                        state <= RUN;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        PRODUCT <= p_next;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state   <= FIN;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
